// File: rtl/axi_slv_wr.sv
// AXI write-only slave with one outstanding burst, backed by a byte-writable word memory.
// Optional build macro AXI_SLV_WR_WLAST_CHK_EN: wlast disagreeing with awlen ends the burst with SLVERR.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_USER_WIDTH
`define AXI_USER_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_slv_wr #(
  parameter int MEM_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [`AXI_ID_WIDTH-1:0]     axi_slv_awid,
  input  logic [`AXI_ADDR_WIDTH-1:0]   axi_slv_awaddr,
  input  logic [`AXI_LEN_WIDTH-1:0]    axi_slv_awlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]   axi_slv_awsize,
  input  logic [`AXI_BURST_WIDTH-1:0]  axi_slv_awburst,
  input  logic [`AXI_USER_WIDTH-1:0]   axi_slv_awuser,
  input  logic                         axi_slv_awvalid,
  output logic                         axi_slv_awready,
  input  logic [`AXI_DATA_WIDTH-1:0]   axi_slv_wdata,
  input  logic [`AXI_DATA_WIDTH/8-1:0] axi_slv_wstrb,
  input  logic                         axi_slv_wlast,
  input  logic [`AXI_USER_WIDTH-1:0]   axi_slv_wuser,
  input  logic                         axi_slv_wvalid,
  output logic                         axi_slv_wready,
  output logic [`AXI_ID_WIDTH-1:0]     axi_slv_bid,
  output logic [`AXI_RESP_WIDTH-1:0]   axi_slv_bresp,
  output logic [`AXI_USER_WIDTH-1:0]   axi_slv_buser,
  output logic                         axi_slv_bvalid,
  input  logic                         axi_slv_bready
);

  // state | meaning
  // IDLE  | awready high, waiting for a write address
  // WDATA | accepting write beats of the latched burst
  // BRESP | presenting the write response until bready

  localparam int AW       = `AXI_ADDR_WIDTH;
  localparam int LW       = `AXI_LEN_WIDTH;
  localparam int SW       = `AXI_SIZE_WIDTH;
  localparam int RW       = `AXI_RESP_WIDTH;
  localparam int STRB_W   = `AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  localparam logic [SW-1:0] MAX_SIZE = SW'(ADDR_LSB);
  localparam logic [RW-1:0] OKAY     = RW'(0);
  localparam logic [RW-1:0] SLVERR   = RW'(2);

  typedef enum logic [1:0] {IDLE, WDATA, BRESP} state_t;

  state_t                       state, state_nxt;
  logic [`AXI_ID_WIDTH-1:0]     id_q;
  logic [AW-1:0]                addr_q, addr_nxt, step, wrap_mask;
  logic [LW-1:0]                len_q, beat_q;
  logic [SW-1:0]                size_q;
  logic [`AXI_BURST_WIDTH-1:0]  burst_q;
  logic [`AXI_USER_WIDTH-1:0]   user_q;
  logic                         err_q;
  logic [RW-1:0]                resp_q;
  logic                         aw_hs, w_hs, last_beat, beat_end, wlast_err;
  logic [IDX_W-1:0]             idx;
  logic                         unused_sig;

  logic [`AXI_DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    axi_slv_awready = 1'b0;
    axi_slv_wready  = 1'b0;
    axi_slv_bvalid  = 1'b0;
    last_beat       = (beat_q == len_q);
`ifdef AXI_SLV_WR_WLAST_CHK_EN
    beat_end  = last_beat || axi_slv_wlast;
    wlast_err = axi_slv_wlast != last_beat;
`else
    beat_end  = last_beat;
    wlast_err = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        axi_slv_awready = !rst;
        if (axi_slv_awvalid && !rst) state_nxt = WDATA;
      end
      WDATA: begin
        axi_slv_wready = !rst;
        if (axi_slv_wvalid && beat_end) state_nxt = BRESP;
      end
      BRESP: begin
        axi_slv_bvalid = 1'b1;
        if (axi_slv_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    aw_hs = axi_slv_awvalid && axi_slv_awready;
    w_hs  = axi_slv_wvalid && axi_slv_wready;
  end

  // WRAP lengths are 2/4/8/16 beats, so the wrap window is a power-of-two mask
  always_comb begin
    step      = AW'(1) << size_q;
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    unique case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      user_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= OKAY;
    end else begin
      if (aw_hs) begin
        id_q    <= axi_slv_awid;
        addr_q  <= axi_slv_awaddr;
        len_q   <= axi_slv_awlen;
        size_q  <= axi_slv_awsize;
        burst_q <= axi_slv_awburst;
        user_q  <= axi_slv_awuser;
        beat_q  <= '0;
        err_q   <= (axi_slv_awburst == 2'b11) || (axi_slv_awsize > MAX_SIZE);
      end
      if (w_hs) begin
        beat_q <= beat_q + LW'(1);
        addr_q <= addr_nxt;
        if (beat_end) resp_q <= (err_q || wlast_err) ? SLVERR : OKAY;
      end
    end
  end

  assign idx = addr_q[ADDR_LSB +: IDX_W];

  // memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_hs && !err_q) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_slv_wstrb[i]) mem[idx][8*i +: 8] <= axi_slv_wdata[8*i +: 8];
      end
    end
  end

  assign axi_slv_bid   = id_q;
  assign axi_slv_buser = user_q;
  assign axi_slv_bresp = resp_q;

  assign unused_sig = ^{axi_slv_wuser, axi_slv_wlast};

endmodule

// File: tb/tb_axi_slv_wr.sv
// Randomized scoreboard bench for axi_slv_wr: driver feeds a byte-level memory model and
// queues expected B responses; a monitor checks each response plus the memory image.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_USER_WIDTH
`define AXI_USER_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_slv_wr;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [`AXI_ID_WIDTH-1:0]     awid = '0;
  logic [`AXI_ADDR_WIDTH-1:0]   awaddr = '0;
  logic [`AXI_LEN_WIDTH-1:0]    awlen = '0;
  logic [`AXI_SIZE_WIDTH-1:0]   awsize = '0;
  logic [`AXI_BURST_WIDTH-1:0]  awburst = '0;
  logic [`AXI_USER_WIDTH-1:0]   awuser = '0;
  logic                         awvalid = 1'b0;
  logic                         awready;
  logic [`AXI_DATA_WIDTH-1:0]   wdata = '0;
  logic [`AXI_DATA_WIDTH/8-1:0] wstrb = '0;
  logic                         wlast = 1'b0;
  logic [`AXI_USER_WIDTH-1:0]   wuser = '0;
  logic                         wvalid = 1'b0;
  logic                         wready;
  logic [`AXI_ID_WIDTH-1:0]     bid;
  logic [`AXI_RESP_WIDTH-1:0]   bresp;
  logic [`AXI_USER_WIDTH-1:0]   buser;
  logic                         bvalid;
  logic                         bready = 1'b1;

  always #5 clk = ~clk;

  axi_slv_wr #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .axi_slv_awid(awid), .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen),
    .axi_slv_awsize(awsize), .axi_slv_awburst(awburst), .axi_slv_awuser(awuser),
    .axi_slv_awvalid(awvalid), .axi_slv_awready(awready),
    .axi_slv_wdata(wdata), .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
    .axi_slv_wuser(wuser), .axi_slv_wvalid(wvalid), .axi_slv_wready(wready),
    .axi_slv_bid(bid), .axi_slv_bresp(bresp), .axi_slv_buser(buser),
    .axi_slv_bvalid(bvalid), .axi_slv_bready(bready)
  );

  typedef struct {
    logic [`AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                 resp;
    logic [`AXI_USER_WIDTH-1:0] user;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  known   [DEPTH];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic check_mem();
    int bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && ((dut.mem[i] ^ ref_mem[i]) & byte_mask(known[i])) !== 32'h0) bad = i;
    n_chk++;
    if (bad < 0) n_pass++;
    else $display("FAIL mem_word[%0d]: got %h expected %h (byte mask %h)",
                  bad, dut.mem[bad], ref_mem[bad], known[bad]);
  endtask

  // Byte address of the next beat, from the burst rules in plain arithmetic
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    int unsigned step, wb, base;
    step = 32'd1 << size;
    wb   = (int'(len) + 1) * step;
    case (burst)
      2'b00: return a;
      2'b10: begin
        base = (a / wb) * wb;
        return base + ((a + step - base) % wb);
      end
      default: return a + step;
    endcase
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (!rst && bvalid && bready) begin
      if (exp_q.size() == 0) check("b_unexpected", 32'(bvalid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("bid", 32'(bid), 32'(mon_e.id));
        check("bresp", 32'(bresp), 32'(mon_e.resp));
        check("buser", 32'(buser), 32'(mon_e.user));
        check_mem();
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] user);
    int n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awuser = user;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input bit last,
                           input bit err, input logic [31:0] a);
    int n = 0;
    int idx;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last; wuser = 4'($urandom);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", 32'(wready), 32'd1);
    else if (!err) begin
      idx = int'((a / 4) % DEPTH);
      for (int i = 0; i < 4; i++)
        if (strb[i]) begin
          ref_mem[idx][8*i +: 8] = data[8*i +: 8];
          known[idx][i] = 1'b1;
        end
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] user,
                          input int early, input int hold_b);
    int nbeats, n;
    bit err, wl_err, lst;
    logic [31:0] a;
    exp_t e;
    err    = (burst == 2'b11) || (size > 3'd2);
    wl_err = 1'b0;
    nbeats = int'(len) + 1;
`ifdef AXI_SLV_WR_WLAST_CHK_EN
    if (early >= 0 && early < int'(len)) begin nbeats = early + 1; wl_err = 1'b1; end
`endif
    e.id = id; e.resp = (err || wl_err) ? 2'b10 : 2'b00; e.user = user;
    exp_q.push_back(e);
    if (hold_b > 0) bready = 1'b0;
    send_aw(id, addr, len, size, burst, user);
    a = addr;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      lst = (early >= 0) ? (b == early) : (b == int'(len));
      send_beat(bd[b], bs[b], lst, err, a);
      a = next_addr(a, size, len, burst);
    end
    check("bvalid_latency", 32'(bvalid), 32'd1);
    check("wready_in_bresp", 32'(wready), 32'd0);
    for (int k = 0; k < hold_b; k++) begin
      wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
      @(negedge clk);
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bid", 32'(bid), 32'(id));
      check("bp_bresp", 32'(bresp), 32'(e.resp));
      check("bp_awready", 32'(awready), 32'd0);
      check("bp_wready", 32'(wready), 32'd0);
    end
    wvalid = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (!bvalid) check("b_timeout", 32'(bvalid), 32'd1);
    else begin
      @(negedge clk);
      check("awready_after_b", 32'(awready), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = '0; end

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_buser", 32'(buser), 32'd0);
    rst = 1'b0;
    #1 check("awready_after_rst", 32'(awready), 32'd1);

    // fill the whole memory so every word is known to the model
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 16; b++) begin bd[b] = $urandom; bs[b] = 4'hF; end
      do_write(4'(blk), 32'(blk * 64), 8'd15, 3'd2, 2'b01, 4'd0, -1, 0);
    end

    bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
    do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 4'd1, -1, 0);
    check("single_mem4", dut.mem[4], 32'hDEADBEEF);

    bd[0] = 32'd1; bd[1] = 32'd2; bd[2] = 32'd3; bd[3] = 32'd4;
    bs[0] = 4'hF;  bs[1] = 4'hF;  bs[2] = 4'h3;  bs[3] = 4'hF;
    do_write(4'd1, 32'h0, 8'd3, 3'd2, 2'b01, 4'd2, -1, 0);
    check("incr_mem0", dut.mem[0], 32'd1);
    check("incr_mem2_low", 32'(dut.mem[2][15:0]), 32'd3);
    check("incr_mem3", dut.mem[3], 32'd4);

    bd[0] = 32'hA; bd[1] = 32'hB; bd[2] = 32'hC; bd[3] = 32'hD;
    for (int b = 0; b < 4; b++) bs[b] = 4'hF;
    do_write(4'd2, 32'h8, 8'd3, 3'd2, 2'b10, 4'd3, -1, 0);
    check("wrap_mem2", dut.mem[2], 32'hA);
    check("wrap_mem3", dut.mem[3], 32'hB);
    check("wrap_mem0", dut.mem[0], 32'hC);
    check("wrap_mem1", dut.mem[1], 32'hD);

    for (int b = 0; b < 4; b++) begin bd[b] = $urandom; bs[b] = 4'hF; end
    do_write(4'd7, 32'h40, 8'd1, 3'd2, 2'b01, 4'd5, -1, 5);

    // wvalid while idle must not be taken
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
      @(negedge clk);
      check("idle_wready", 32'(wready), 32'd0);
    end
    wvalid = 1'b0;

    for (int b = 0; b < 4; b++) begin bd[b] = $urandom; bs[b] = 4'hF; end
    do_write(4'd9, 32'h80, 8'd3, 3'd2, 2'b01, 4'd6, 1, 0);

    for (int b = 0; b < 4; b++) begin bd[b] = $urandom; bs[b] = 4'hF; end
    do_write(4'd4, 32'h20, 8'd2, 3'd2, 2'b11, 4'd7, -1, 0);
    do_write(4'd5, 32'h30, 8'd1, 3'd3, 2'b01, 4'd8, -1, 0);

    // reset in the middle of a burst abandons it
    for (int b = 0; b < 4; b++) begin bd[b] = $urandom; bs[b] = 4'hF; end
    send_aw(4'd6, 32'h60, 8'd3, 3'd2, 2'b01, 4'd9);
    send_beat(bd[0], bs[0], 1'b0, 1'b0, 32'h60);
    send_beat(bd[1], bs[1], 1'b0, 1'b0, 32'h64);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check("midrst_awready", 32'(awready), 32'd0);
    check("midrst_wready", 32'(wready), 32'd0);
    check("midrst_bvalid", 32'(bvalid), 32'd0);
    check("midrst_bid", 32'(bid), 32'd0);
    rst = 1'b0;
    #1 check("midrst_awready_after", 32'(awready), 32'd1);
    @(negedge clk);
    check("midrst_no_bvalid", 32'(bvalid), 32'd0);
    bd[0] = $urandom; bs[0] = 4'hF;
    do_write(4'd11, 32'h100, 8'd0, 3'd2, 2'b01, 4'd10, -1, 0);

    for (int t = 0; t < 40; t++) begin
      burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (burst == 2'b10) len = 8'((1 << $urandom_range(1, 4)) - 1);
      else                len = 8'($urandom_range(0, 15));
      addr = 32'($urandom_range(0, 1023));
      addr = (addr >> size) << size;
      for (int b = 0; b < 16; b++) begin bd[b] = $urandom; bs[b] = 4'($urandom); end
      do_write(4'($urandom), addr, len, size, burst, 4'($urandom), -1,
               int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("b_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
